// File: rtl/uart_mem_responder.sv
// UART memory responder: decodes read/write request packets into a local RAM.
// Define UART_MEM_CHECKSUM_EN to require a trailing XOR checksum byte per request.
module uart_mem_responder #(
    parameter int    ADDR_W  = 17,
    parameter int    TIMEOUT = 1000000,
    parameter string INIT    = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ack,
    output logic [7:0]  tx_data,
    output logic        tx_en,
    input  logic        tx_ack,
    output logic        busy,
    output logic [15:0] drop_cnt
);

    typedef enum logic [3:0] {
        IDLE, ADDR, WDATA, RREQ, RSEND, WACK, CK, WCOMMIT, NACK, RCK
    } state_t;

    state_t state, state_n;

    logic [ADDR_W-1:0] addr, cur_a;
    logic [1:0]        a_cnt, idx, len;
    logic              is_wr;
    logic [31:0]       tmo;
    logic [7:0]        mem [0:(1<<ADDR_W)-1];
    logic [7:0]        rd_q, tx_byte, wd;
    logic              we, take, rx_ok, timed, tx_send, tx_done, last, drop;
`ifdef UART_MEM_CHECKSUM_EN
    logic [7:0]        csum, dsum;
    logic [7:0]        wbuf [4];
`endif

    assign cur_a   = addr + ADDR_W'(idx);
    assign last    = (idx == len);
    assign rx_ok   = state inside {IDLE, ADDR, WDATA, CK};
    assign take    = rx_ok && rx_valid && !rx_ack;
    assign timed   = state inside {ADDR, WDATA, CK};
    assign tx_send = state inside {RSEND, WACK, NACK, RCK};
    assign tx_done = tx_en && tx_ack;
    assign busy    = (state != IDLE);

    always_comb begin
        state_n = state;
        we      = 1'b0;
        wd      = rx_data;
        tx_byte = 8'h00;
        drop    = 1'b0;
        case (state)
            IDLE: if (take) state_n = ADDR;
            ADDR: if (take && a_cnt == 2'd3) begin
`ifdef UART_MEM_CHECKSUM_EN
                state_n = is_wr ? WDATA : CK;
`else
                state_n = is_wr ? WDATA : RREQ;
`endif
            end
            WDATA: if (take) begin
`ifdef UART_MEM_CHECKSUM_EN
                if (last) state_n = CK;
`else
                we = 1'b1;
                if (last) state_n = WACK;
`endif
            end
            RREQ: state_n = RSEND;
            RSEND: begin
                tx_byte = rd_q;
                if (tx_done) begin
                    if (!last) state_n = RREQ;
`ifdef UART_MEM_CHECKSUM_EN
                    else state_n = RCK;
`else
                    else state_n = IDLE;
`endif
                end
            end
            WACK: begin
                tx_byte = 8'hA5;
                if (tx_done) state_n = IDLE;
            end
`ifdef UART_MEM_CHECKSUM_EN
            CK: if (take) begin
                if (rx_data == csum) begin
                    state_n = is_wr ? WCOMMIT : RREQ;
                end else begin
                    state_n = NACK;
                    drop    = 1'b1;
                end
            end
            WCOMMIT: begin
                we = 1'b1;
                wd = wbuf[idx];
                if (last) state_n = WACK;
            end
            NACK: begin
                tx_byte = 8'h5A;
                if (tx_done) state_n = IDLE;
            end
            RCK: begin
                tx_byte = dsum;
                if (tx_done) state_n = IDLE;
            end
`endif
            default: state_n = IDLE;
        endcase
        // Silence between bytes of a request abandons it without a reply
        if (timed && !take && tmo >= 32'(TIMEOUT - 1)) begin
            state_n = IDLE;
            drop    = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rx_ack   <= 1'b0;
            tx_en    <= 1'b0;
            tx_data  <= 8'h00;
            drop_cnt <= 16'h0000;
            tmo      <= 32'd0;
            addr     <= '0;
            a_cnt    <= 2'd0;
            idx      <= 2'd0;
            len      <= 2'd0;
            is_wr    <= 1'b0;
`ifdef UART_MEM_CHECKSUM_EN
            csum     <= 8'h00;
            dsum     <= 8'h00;
`endif
        end else begin
            state  <= state_n;
            rx_ack <= take;
            tmo    <= (take || !timed) ? 32'd0 : tmo + 32'd1;
            if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            if (tx_done) begin
                tx_en <= 1'b0;
            end else if (tx_send && !tx_en) begin
                tx_en   <= 1'b1;
                tx_data <= tx_byte;
            end
            if (take && state == IDLE) begin
                is_wr <= rx_data[7];
                len   <= rx_data[1:0];
                a_cnt <= 2'd0;
                idx   <= 2'd0;
`ifdef UART_MEM_CHECKSUM_EN
                csum  <= rx_data;
                dsum  <= 8'h00;
`endif
            end
            if (take && state == ADDR) begin
                a_cnt <= a_cnt + 2'd1;
                for (int i = 0; i < ADDR_W; i++)
                    if (i / 8 == int'(a_cnt)) addr[i] <= rx_data[i % 8];
            end
            if ((take && state == WDATA) || state == WCOMMIT ||
                (state == RSEND && tx_done))
                idx <= last ? 2'd0 : idx + 2'd1;
`ifdef UART_MEM_CHECKSUM_EN
            if (take && (state == ADDR || state == WDATA)) csum <= csum ^ rx_data;
            if (state == RSEND && tx_done) dsum <= dsum ^ rd_q;
`endif
        end
    end

`ifdef UART_MEM_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (take && state == WDATA) wbuf[idx] <= rx_data;
    end
`endif

    // RAM contents survive reset, so this port has no reset
    always_ff @(posedge clk) begin
        if (we) mem[cur_a] <= wd;
        rd_q <= mem[cur_a];
    end

endmodule
